// File: rtl/spi_cmd_rx.sv
// SPI/QPI command receiver: decodes register and memory write frames
// clocked by the SPI clock, with a runtime standard/quad lane switch.
module spi_cmd_rx (
  input  logic        spi_clk_i,
  input  logic        rst_n,
  input  logic        spi_cs_i,
  input  logic        spi_sdi0_i,
  input  logic        spi_sdi1_i,
  input  logic        spi_sdi2_i,
  input  logic        spi_sdi3_i,
  output logic        qpi_en_o,
  output logic        reg_wr_o,
  output logic        reg_sel_o,
  output logic [7:0]  reg_wdata_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        cmd_err_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE, CMD, REG_DATA, ADDR, DATA, DONE, IGNORE
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;
  logic        armed_q, armed_d;
  logic        sel_q, sel_d;
  logic        pend_q, pend_d;
  logic        qpi_q, qpi_d;
  logic        reg_wr_q, reg_wr_d;
  logic        reg_sel_q, reg_sel_d;
  logic [7:0]  reg_wdata_q, reg_wdata_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        err_q, err_d;

  logic [3:0]  nib;
  logic [5:0]  inc, cnt_nx;
  logic [31:0] sh_nx;
  logic        wide, field_end;
  logic        is_reg, is_mem;

  assign nib    = {spi_sdi3_i, spi_sdi2_i, spi_sdi1_i, spi_sdi0_i};
  assign inc    = qpi_q ? 6'd4 : 6'd1;
  assign cnt_nx = cnt_q + inc;
  assign sh_nx  = qpi_q ? {sh_q[27:0], nib} : {sh_q[30:0], spi_sdi0_i};
  assign wide   = (state_q == ADDR) || (state_q == DATA);
  assign field_end = (cnt_nx == (wide ? 6'd32 : 6'd8));
  assign is_reg = (sh_nx[7:0] == 8'h01) || (sh_nx[7:0] == 8'h11);
  assign is_mem = (sh_nx[7:0] == 8'h02);

  always_ff @(posedge spi_clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (spi_cs_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:     if (armed_q) state_d = CMD;
        CMD:      if (field_end) begin
                    if (is_reg)      state_d = REG_DATA;
                    else if (is_mem) state_d = ADDR;
                    else             state_d = IGNORE;
                  end
        REG_DATA: if (field_end) state_d = DONE;
        ADDR:     if (field_end) state_d = DATA;
        DATA:     if (field_end) state_d = DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    armed_d     = armed_q;
    sel_d       = sel_q;
    pend_d      = pend_q;
    qpi_d       = qpi_q;
    reg_wr_d    = 1'b0;
    mem_wr_d    = 1'b0;
    err_d       = 1'b0;
    reg_sel_d   = reg_sel_q;
    reg_wdata_d = reg_wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (spi_cs_i) begin
      // Frame boundary: the pending lane mode becomes live here only
      cnt_d   = '0;
      armed_d = 1'b1;
      qpi_d   = pend_q;
    end else begin
      unique case (state_q)
        IDLE: if (armed_q) begin
          sh_d  = sh_nx;
          cnt_d = cnt_nx;
        end
        CMD: begin
          sh_d  = sh_nx;
          cnt_d = field_end ? 6'd0 : cnt_nx;
          if (field_end) begin
            sel_d = sh_nx[4];
            err_d = !is_reg && !is_mem;
          end
        end
        REG_DATA: begin
          sh_d  = sh_nx;
          cnt_d = field_end ? 6'd0 : cnt_nx;
          if (field_end) begin
            reg_wr_d    = 1'b1;
            reg_sel_d   = sel_q;
            reg_wdata_d = sh_nx[7:0];
            if (!sel_q) pend_d = sh_nx[0];
          end
        end
        ADDR: begin
          sh_d  = sh_nx;
          cnt_d = field_end ? 6'd0 : cnt_nx;
          if (field_end) mem_addr_d = sh_nx;
        end
        DATA: begin
          sh_d  = sh_nx;
          cnt_d = field_end ? 6'd0 : cnt_nx;
          if (field_end) begin
            mem_wr_d    = 1'b1;
            mem_wdata_d = sh_nx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge spi_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      sh_q        <= '0;
      armed_q     <= 1'b0;
      sel_q       <= 1'b0;
      pend_q      <= 1'b0;
      qpi_q       <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_sel_q   <= 1'b0;
      reg_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      armed_q     <= armed_d;
      sel_q       <= sel_d;
      pend_q      <= pend_d;
      qpi_q       <= qpi_d;
      reg_wr_q    <= reg_wr_d;
      reg_sel_q   <= reg_sel_d;
      reg_wdata_q <= reg_wdata_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign qpi_en_o    = qpi_q;
  assign reg_wr_o    = reg_wr_q;
  assign reg_sel_o   = reg_sel_q;
  assign reg_wdata_o = reg_wdata_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign cmd_err_o   = err_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Directed bench for spi_cmd_rx: reg/mem frames, lane switching,
// aborted frames, unknown commands and mid-frame reset.
module tb_spi_cmd_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic        sdi0, sdi1, sdi2, sdi3;
  logic        qpi_en, reg_wr, reg_sel, mem_wr, cmd_err, busy;
  logic [7:0]  reg_wdata;
  logic [31:0] mem_addr, mem_wdata;

  int n_chk = 0;
  int n_fail = 0;
  int n_reg = 0;
  int n_mem = 0;
  int n_err = 0;
  int n_viol = 0;
  logic prev_any = 1'b0;

  always #5 clk = ~clk;

  spi_cmd_rx dut (
    .spi_clk_i   (clk),
    .rst_n       (rst_n),
    .spi_cs_i    (cs),
    .spi_sdi0_i  (sdi0),
    .spi_sdi1_i  (sdi1),
    .spi_sdi2_i  (sdi2),
    .spi_sdi3_i  (sdi3),
    .qpi_en_o    (qpi_en),
    .reg_wr_o    (reg_wr),
    .reg_sel_o   (reg_sel),
    .reg_wdata_o (reg_wdata),
    .mem_wr_o    (mem_wr),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .cmd_err_o   (cmd_err),
    .busy_o      (busy)
  );

  // Strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    int s;
    s = int'(reg_wr) + int'(mem_wr) + int'(cmd_err);
    if (reg_wr)  n_reg++;
    if (mem_wr)  n_mem++;
    if (cmd_err) n_err++;
    if (s > 1 || (prev_any && s > 0)) n_viol++;
    prev_any = (s > 0);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    cs = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame(input logic [71:0] d, input int n,
                       input bit quad, input bit close);
    int step;
    step = quad ? 4 : 1;
    for (int i = n - 1; i >= 0; i -= step) begin
      @(negedge clk);
      cs = 1'b0;
      if (quad) {sdi3, sdi2, sdi1, sdi0} = d[i -: 4];
      else      sdi0 = d[i];
    end
    if (close) end_frame();
  endtask

  initial begin
    int r0, m0, e0;
    cs = 1'b1; rst_n = 1'b0;
    {sdi3, sdi2, sdi1, sdi0} = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_qpi", 32'(qpi_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_strobes", 32'({reg_wr, mem_wr, cmd_err}), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Standard reg0 write enabling quad mode
    r0 = n_reg;
    frame(72'h0101, 16, 0, 0);
    @(negedge clk);
    chk("std_r0_qpi_in_frame", 32'(qpi_en), 32'h0);
    end_frame();
    chk("std_r0_cnt", n_reg - r0, 1);
    chk("std_r0_sel", 32'(reg_sel), 32'h0);
    chk("std_r0_data", 32'(reg_wdata), 32'h01);
    chk("std_r0_qpi", 32'(qpi_en), 32'h1);
    chk("std_r0_busy", 32'(busy), 32'h0);

    // Quad memory write, 18 nibbles
    m0 = n_mem;
    frame(72'h02_1A107008_DEADBEEF, 72, 1, 1);
    chk("q_mem_cnt", n_mem - m0, 1);
    chk("q_mem_addr", mem_addr, 32'h1A107008);
    chk("q_mem_data", mem_wdata, 32'hDEADBEEF);

    // Quad reg0 write back to standard
    r0 = n_reg;
    frame(72'h0100, 16, 1, 1);
    chk("q_r0_cnt", n_reg - r0, 1);
    chk("q_r0_qpi", 32'(qpi_en), 32'h0);

    // Unknown command in standard mode
    r0 = n_reg; m0 = n_mem; e0 = n_err;
    frame(72'h55, 8, 0, 0);
    frame(72'hF, 4, 0, 0);
    chk("err_busy", 32'(busy), 32'h1);
    chk("err_cnt", n_err - e0, 1);
    end_frame();
    chk("err_busy_after", 32'(busy), 32'h0);
    chk("err_no_wr", (n_reg - r0) + (n_mem - m0), 0);

    // Aborted address phase, then reg1 write
    r0 = n_reg; m0 = n_mem;
    frame({8'h02, 20'hABCDE}, 28, 0, 1);
    frame(72'h11A5, 16, 0, 1);
    chk("abort_no_mem", n_mem - m0, 0);
    chk("abort_addr_hold", mem_addr, 32'h1A107008);
    chk("r1_cnt", n_reg - r0, 1);
    chk("r1_sel", 32'(reg_sel), 32'h1);
    chk("r1_data", 32'(reg_wdata), 32'hA5);
    chk("r1_qpi", 32'(qpi_en), 32'h0);

    // Extra bits after a complete reg write
    r0 = n_reg; e0 = n_err;
    frame(72'h113CFF, 24, 0, 1);
    chk("extra_cnt", n_reg - r0, 1);
    chk("extra_err", n_err - e0, 0);
    chk("extra_data", 32'(reg_wdata), 32'h3C);

    // Reset during quad DATA phase
    frame(72'h0101, 16, 0, 1);
    chk("pre_rst_qpi", 32'(qpi_en), 32'h1);
    m0 = n_mem;
    frame({8'h02, 32'h12345678, 12'hABC}, 52, 1, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_qpi", 32'(qpi_en), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_wdata", mem_wdata, 32'h0);
    chk("mid_rst_reg", {23'h0, reg_sel, reg_wdata}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r0 = n_reg;
    frame(72'h0101, 16, 0, 0);
    chk("unarmed_busy", 32'(busy), 32'h0);
    chk("unarmed_no_wr", n_reg - r0, 0);
    end_frame();
    frame(72'h1177, 16, 0, 1);
    chk("post_rst_cnt", n_reg - r0, 1);
    chk("post_rst_data", 32'(reg_wdata), 32'h77);
    chk("post_rst_sel", 32'(reg_sel), 32'h1);
    chk("post_rst_mem", n_mem - m0, 0);
    chk("post_rst_qpi", 32'(qpi_en), 32'h0);

    chk("strobe_excl", n_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_rx.md
SPI_CMD_RX -- requirements
Module: spi_cmd_rx

Interface
REQ-001 SHALL have one clock and reset: asynchronous, active-low.
REQ-002 SHALL have port spi_clk_i, input, 1 bit: the only clock; all sampling on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port spi_cs_i, input, 1 bit: chip select, active low; low means frame active.
REQ-005 SHALL have ports spi_sdi0_i..spi_sdi3_i, input, 1 bit each: serial data lines.
REQ-006 SHALL have port qpi_en_o, output, 1 bit: current lane mode; 0 = standard (sdi0 only), 1 = quad.
REQ-007 SHALL have port reg_wr_o, output, 1 bit: one-cycle register-write strobe.
REQ-008 SHALL have port reg_sel_o, output, 1 bit: register index (0 = reg0, 1 = reg1).
REQ-009 SHALL have port reg_wdata_o, output, 8 bits: register write data.
REQ-010 SHALL have port mem_wr_o, output, 1 bit: one-cycle memory-write strobe.
REQ-011 SHALL have port mem_addr_o, output, 32 bits: memory write address.
REQ-012 SHALL have port mem_wdata_o, output, 32 bits: memory write data.
REQ-013 SHALL have port cmd_err_o, output, 1 bit: one-cycle pulse on an unknown command.
REQ-014 SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.

Function
REQ-015 SHALL sample a bit on each rising edge with spi_cs_i low.
- Standard mode: one bit per cycle from sdi0, MSB first.
- Quad mode: one nibble per cycle, {sdi3,sdi2,sdi1,sdi0}, sdi3 most significant, MS nibble first.
REQ-016 SHALL implement states IDLE, CMD, REG_DATA, ADDR, DATA, DONE, IGNORE.
REQ-017 From IDLE, the first edge with spi_cs_i low SHALL capture the first command bit or nibble and enter CMD.
REQ-018 After the 8-bit command is complete, the state SHALL change as follows:
- 0x01 -> REG_DATA with reg_sel=0.
- 0x11 -> REG_DATA with reg_sel=1.
- 0x02 -> ADDR.
- Any other value -> IGNORE, with cmd_err_o pulsed high for exactly one cycle.
REQ-019 REG_DATA SHALL collect 8 bits, then enter DONE. On the edge that captures the last bit, it SHALL register reg_wdata_o and reg_sel_o and set reg_wr_o high for the following cycle only.
REQ-020 ADDR SHALL collect 32 bits into mem_addr_o, then enter DATA. DATA SHALL collect 32 bits, then enter DONE. On the last DATA bit, mem_wr_o SHALL pulse high for one cycle with mem_addr_o/mem_wdata_o stable.
REQ-021 Frame lengths SHALL be:
- Standard: reg write 16 cycles, mem write 72 cycles.
- Quad: reg write 4 cycles, mem write 18 cycles.
REQ-022 DONE and IGNORE SHALL discard all sampled bits until spi_cs_i is high; one command per frame.
REQ-023 spi_cs_i high in any state SHALL force IDLE on that edge and clear the bit counter. No strobe SHALL issue for a partial frame. Previously registered data outputs SHALL hold.
REQ-024 A reg0 write with reg_wdata bit0 SHALL set the new qpi_en_o to that bit.
- The change takes effect at the IDLE transition, so mode is constant within a frame.
- A reg1 write SHALL not affect qpi_en_o.
REQ-025 The bit counter SHALL be 6 bits. Mode-dependent increments are 1 (standard) or 4 (quad). The counter SHALL clear on every field completion and SHALL never wrap within a field.
REQ-026 If spi_cs_i rises on the same edge that captures a field's last bit, the capture and strobe SHALL take effect, then the state SHALL go to IDLE.
REQ-027 reg_wr_o, mem_wr_o and cmd_err_o SHALL be mutually exclusive and SHALL never be high for two consecutive cycles.

Reset
REQ-028 rst_n low SHALL immediately force IDLE and set every output to 0, including qpi_en_o, mem_addr_o and mem_wdata_o.
REQ-029 Reset mid-frame SHALL discard the frame. After rst_n rises, decoding SHALL start only after spi_cs_i has been seen high, then low.

Verification
REQ-030 Standard reg0 write: cmd 0x01, data 0x01 -> reg_wr_o pulses once with reg_sel_o=0 and reg_wdata_o=0x01; qpi_en_o=1 after cs_i rises.
REQ-031 Quad mem write: cmd 0x02, addr 0x1A107008, data 0xDEADBEEF over 18 cycles -> one mem_wr_o pulse with those values.
REQ-032 Standard cmd 0x55 -> cmd_err_o high for one cycle; no write strobes; busy_o stays high until cs_i rises.
REQ-033 spi_cs_i raised after 20 of 32 ADDR bits, then a full reg1 write of 0xA5 -> no mem_wr_o; reg_wr_o with reg_sel_o=1 and reg_wdata_o=0xA5; qpi_en_o unchanged.
REQ-034 rst_n asserted during DATA in quad mode -> all outputs 0, qpi_en_o=0; the next frame decodes in standard mode.
REQ-035 Extra bits after a complete reg write while cs_i stays low -> exactly one reg_wr_o pulse; no cmd_err_o.
